// File: rtl/pc_sequencer.sv
// Program-counter register and fetch sequencer for the pipelined core.
// Merges PC+4, hazard stalls and EX-stage redirects into one PC update per cycle.
module pc_sequencer #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             FetchAck,
  output logic [PC_W-1:0]  PC,
  output logic             FetchReq,
  output logic             FlushIfId,
  output logic             FlushIdEx,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PC_W-1:0]  pc_d;
  logic             mis_d;
  logic [CNT_W-1:0] cnt_d;
  logic             take;
  logic             unused_br;

  assign unused_br = ^{BrPC[31:PC_W], BrPC[0]};

  // Redirects are only honoured in RUN; REDIRECT holds a flushed bubble in EX.
  assign take      = (state_q == RUN) && PcSel;
  assign FlushIfId = take;
  assign FlushIdEx = take;

  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    mis_d   = 1'b0;
    cnt_d   = RedirectCount;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, REDIRECT: begin
        state_d = RUN;
        if (take) begin
          pc_d    = {BrPC[PC_W-1:2], 2'b00};
          mis_d   = BrPC[1];
          state_d = REDIRECT;
          if (RedirectCount != '1)
            cnt_d = RedirectCount + CNT_W'(1);
        end else if (Stall) begin
          pc_d = PC;
        end else if (FetchAck) begin
          pc_d = PC + PC_W'(4);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      PC            <= {RESET_PC[PC_W-1:2], 2'b00};
      FetchReq      <= 1'b0;
      MisalignErr   <= 1'b0;
      RedirectCount <= '0;
    end else begin
      state_q       <= state_d;
      PC            <= pc_d;
      FetchReq      <= (state_d != BOOT);
      MisalignErr   <= mis_d;
      RedirectCount <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Each cycle: drive at posedge+1, check at posedge+2.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        FetchAck;
  logic [8:0]  PC;
  logic        FetchReq;
  logic        FlushIfId;
  logic        FlushIdEx;
  logic        MisalignErr;
  logic [3:0]  RedirectCount;

  int checks = 0;
  int passed = 0;

  pc_sequencer #(
    .PC_W(9),
    .RESET_PC(9'h000),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .PcSel(PcSel),
    .BrPC(BrPC),
    .FetchAck(FetchAck),
    .PC(PC),
    .FetchReq(FetchReq),
    .FlushIfId(FlushIfId),
    .FlushIdEx(FlushIdEx),
    .MisalignErr(MisalignErr),
    .RedirectCount(RedirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Stall = 1'b0; PcSel = 1'b1;
    BrPC = 32'h80; FetchAck = 1'b1;
    repeat (3) next_cycle();
    #1;
    checks++;
    if (PC !== 9'h000) $display("FAIL rst_pc got %h want 000", PC);
    else passed++;
    checks++;
    if (FetchReq !== 1'b0) $display("FAIL rst_req got %b want 0", FetchReq);
    else passed++;
    checks++;
    if ({FlushIfId, FlushIdEx} !== 2'b00)
      $display("FAIL rst_flush got %b want 00", {FlushIfId, FlushIdEx});
    else passed++;
    checks++;
    if ({MisalignErr, RedirectCount} !== 5'h00)
      $display("FAIL rst_cnt got %h want 00", {MisalignErr, RedirectCount});
    else passed++;
    PcSel = 1'b0;
  endtask

  task automatic test_boot();
    reset = 1'b1;
    #1;
    checks++;
    if ({FetchReq, PC} !== {1'b0, 9'h000})
      $display("FAIL boot0 got %b/%h want 0/000", FetchReq, PC);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      checks++;
      if ({FetchReq, PC} !== {1'b1, 9'(i * 4)})
        $display("FAIL boot_seq%0d got %b/%h want 1/%h",
                 i, FetchReq, PC, 9'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({FetchReq, FlushIfId, FlushIdEx, PC} !== {3'b100, 9'h010})
        $display("FAIL stall%0d got %b%b%b/%h want 100/010",
                 i, FetchReq, FlushIfId, FlushIdEx, PC);
      else passed++;
      next_cycle();
    end
    Stall = 1'b0;
    #1;
    checks++;
    if (PC !== 9'h010) $display("FAIL stall_rel got %h want 010", PC);
    else passed++;
    next_cycle();
    #1;
    checks++;
    if (PC !== 9'h014) $display("FAIL stall_next got %h want 014", PC);
    else passed++;
  endtask

  task automatic test_redirect_priority();
    PcSel = 1'b1; BrPC = 32'h0000_0040; Stall = 1'b1; FetchAck = 1'b0;
    #1;
    checks++;
    if ({FlushIfId, FlushIdEx} !== 2'b11)
      $display("FAIL rd_flush got %b want 11", {FlushIfId, FlushIdEx});
    else passed++;
    next_cycle();
    BrPC = 32'h0000_0100; Stall = 1'b0; FetchAck = 1'b1;
    #1;
    checks++;
    if ({PC, RedirectCount} !== {9'h040, 4'h1})
      $display("FAIL rd_pc got %h/%h want 040/1", PC, RedirectCount);
    else passed++;
    checks++;
    if ({FlushIfId, FlushIdEx, FetchReq, MisalignErr} !== 4'b0010)
      $display("FAIL rd_bubble got %b want 0010",
               {FlushIfId, FlushIdEx, FetchReq, MisalignErr});
    else passed++;
    next_cycle();
    PcSel = 1'b0;
    #1;
    checks++;
    if ({PC, RedirectCount} !== {9'h044, 4'h1})
      $display("FAIL rd_ignored got %h/%h want 044/1", PC, RedirectCount);
    else passed++;
  endtask

  task automatic test_misalign();
    PcSel = 1'b1; BrPC = 32'h0000_0262;
    #1;
    checks++;
    if ({FlushIfId, MisalignErr} !== 2'b10)
      $display("FAIL mis_pre got %b want 10", {FlushIfId, MisalignErr});
    else passed++;
    next_cycle();
    PcSel = 1'b0;
    #1;
    checks++;
    if ({PC, MisalignErr, RedirectCount} !== {9'h060, 1'b1, 4'h2})
      $display("FAIL mis_hit got %h/%b/%h want 060/1/2",
               PC, MisalignErr, RedirectCount);
    else passed++;
    next_cycle();
    #1;
    checks++;
    if ({PC, MisalignErr} !== {9'h064, 1'b0})
      $display("FAIL mis_pulse got %h/%b want 064/0", PC, MisalignErr);
    else passed++;
  endtask

  task automatic test_wrap();
    PcSel = 1'b1; BrPC = 32'hFFFF_FFFC;
    next_cycle();
    PcSel = 1'b0;
    #1;
    checks++;
    if ({PC, MisalignErr} !== {9'h1FC, 1'b0})
      $display("FAIL wrap_pre got %h/%b want 1fc/0", PC, MisalignErr);
    else passed++;
    next_cycle();
    #1;
    checks++;
    if (PC !== 9'h000) $display("FAIL wrap got %h want 000", PC);
    else passed++;
  endtask

  task automatic test_saturation_reset();
    PcSel = 1'b1; FetchAck = 1'b1;
    for (int i = 0; i < 20; i++) begin
      BrPC = 32'(i * 8);
      next_cycle();
      next_cycle();
      if (i == 4) begin
        checks++;
        if (RedirectCount !== 4'h8)
          $display("FAIL sat_mid got %h want 8", RedirectCount);
        else passed++;
      end
    end
    #1;
    checks++;
    if (RedirectCount !== 4'hF)
      $display("FAIL sat got %h want f", RedirectCount);
    else passed++;
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({PC, RedirectCount, FetchReq} !== {9'h000, 4'h0, 1'b0})
      $display("FAIL async_rst got %h/%h/%b want 000/0/0",
               PC, RedirectCount, FetchReq);
    else passed++;
    checks++;
    if ({FlushIfId, FlushIdEx, MisalignErr} !== 3'b000)
      $display("FAIL async_flush got %b want 000",
               {FlushIfId, FlushIdEx, MisalignErr});
    else passed++;
    PcSel = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({FetchReq, PC} !== {1'b0, 9'h000})
      $display("FAIL reboot got %b/%h want 0/000", FetchReq, PC);
    else passed++;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if ({FetchReq, PC, RedirectCount} !== {1'b1, 9'h004, 4'h0})
      $display("FAIL reboot_run got %b/%h/%h want 1/004/0",
               FetchReq, PC, RedirectCount);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_priority();
    test_misalign();
    test_wrap();
    test_saturation_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
